// File: rtl/audio_pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM audio generator.
// Frame layout: channel c occupies bits [c*DATA_W +: DATA_W].
package audio_pwm_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_NUM_CH   = 2;
  localparam int unsigned DEF_PRESCALE = 1;

  // Helper widths bound the parametrisation: DATA_W <= 16, frame <= 256 bits.
  localparam int unsigned MAX_DATA_W  = 16;
  localparam int unsigned MAX_FRAME_W = 256;

  localparam int unsigned PERIOD_MAX = (32'd1 << DEF_DATA_W) - 32'd1;

  function automatic int unsigned period_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] frame_ch(
    input logic [MAX_FRAME_W-1:0] frame,
    input int unsigned            c,
    input int unsigned            w
  );
    return MAX_DATA_W'(frame >> (c * w)) & ({MAX_DATA_W{1'b1}} >> (MAX_DATA_W - w));
  endfunction

endpackage

// File: rtl/audio_pwm_channel.sv
// One PWM channel: active compare register swapped in at period boundaries,
// compare against the shared counter and mute/enable gating into a registered pin.
module audio_pwm_channel
  import audio_pwm_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              mute_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] pend_i,
  input  logic [DATA_W-1:0] cnt_i,
  output logic              pwm_o
);

  logic [DATA_W-1:0] active_q, active_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    active_d = active_q;
    if (load_i) begin
      active_d = pend_i;
    end
    // Strict less-than: zero never drives high, all-ones leaves one low tick.
    pwm_d = en_i & ~mute_i & (cnt_i < active_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/audio_pwm_multi.sv
// Multi-channel PWM audio generator: prescaled period counter, one-frame pending
// buffer on valid/ready, frame swap only at period boundaries, sticky underrun.
module audio_pwm_multi
  import audio_pwm_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic [NUM_CH-1:0]        mute,
  input  logic                     underrun_clr,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start,
  output logic                     underrun
);

  localparam int unsigned       PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DATA_W-1:0] CNT_MAX  = DATA_W'(period_max(DATA_W));

  logic [PW-1:0]              presc_q, presc_d;
  logic [DATA_W-1:0]          cnt_q, cnt_d;
  logic [NUM_CH*DATA_W-1:0]   pend_q, pend_d;
  logic                       pend_full_q, pend_full_d;
  logic                       underrun_q, underrun_d;
  logic                       pstart_q, pstart_d;
  logic                       tick, boundary, accept, load;

  always_comb begin
    tick     = enable && (presc_q == PRE_LAST);
    boundary = tick && (cnt_q == CNT_MAX);
    accept   = sample_valid && !pend_full_q;
    load     = boundary && pend_full_q;

    presc_d = presc_q + PW'(1);
    if (!enable || tick) begin
      presc_d = '0;
    end

    // Counter wraps naturally at the boundary; disable parks it at zero.
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + DATA_W'(1);
    end

    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (load) begin
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = sample_data;
      pend_full_d = 1'b1;
    end

    // A missed frame outranks a simultaneous clear request.
    underrun_d = underrun_q;
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (boundary && !pend_full_q) begin
      underrun_d = 1'b1;
    end

    pstart_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      pstart_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      underrun_q  <= underrun_d;
      pstart_q    <= pstart_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] pend_ch;
    logic              pwm_ch;

    assign pend_ch = DATA_W'(frame_ch(MAX_FRAME_W'(pend_q), c, DATA_W));

    audio_pwm_channel #(
      .DATA_W (DATA_W)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en_i   (enable),
      .mute_i (mute[c]),
      .load_i (load),
      .pend_i (pend_ch),
      .cnt_i  (cnt_q),
      .pwm_o  (pwm_ch)
    );

    assign pwm_out[c] = pwm_ch;
  end

  assign sample_ready = !pend_full_q;
  assign period_start = pstart_q;
  assign underrun     = underrun_q;

endmodule
